// File: rtl/output_port_arbiter.sv
// Per-output-port allocator for the router crossbar.
// Picks one of NPORT inputs with round-robin priority that rotates per packet.
// Holds the winner for the whole packet (wormhole lock).
// Gates every grant on a downstream credit counter.
module output_port_arbiter #(
  parameter int unsigned NPORT = 5,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] tail,
  input  logic             credit_in,
  output logic [NPORT-1:0] grant,
  output logic             busy,
  output logic [CNTW-1:0]  credit_cnt,
  output logic             cred_err
);

  localparam int unsigned W2 = 2 * NPORT;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [NPORT-1:0] r_ptr;
  logic [NPORT-1:0] r_lock;
  logic [CNTW-1:0]  r_cnt;
  logic             r_err;

  logic [NPORT-1:0] w_base;
  logic [W2-1:0]    w_dbl_req;
  logic [W2-1:0]    w_dbl_gnt;
  logic [NPORT-1:0] w_rr_gnt;
  logic [NPORT-1:0] w_grant;
  logic             w_xfer;
  logic             w_win_tail;
  logic             w_cnt_full;

  // Round-robin pick: the search starts one port above the last winner.
  // Doubling the request vector lets the borrow of (req - base) wrap past
  // port NPORT-1 back to port 0; the lowest set bit at or above base wins.
  always_comb begin
    w_base    = {r_ptr[NPORT-2:0], r_ptr[NPORT-1]};
    w_dbl_req = {req, req};
    w_dbl_gnt = w_dbl_req & ~(w_dbl_req - {{NPORT{1'b0}}, w_base});
    w_rr_gnt  = w_dbl_gnt[NPORT-1:0] | w_dbl_gnt[W2-1:NPORT];
  end

  // Combinational grant: blocked in reset and without credit, locked port only while LOCKED.
  always_comb begin
    w_grant = '0;
    if (!rst && (r_cnt != '0)) begin
      if (r_state == LOCKED) begin
        w_grant = r_lock & req;
      end else begin
        w_grant = w_rr_gnt;
      end
    end
  end

  assign w_xfer     = |w_grant;
  assign w_win_tail = |(w_grant & tail);
  assign w_cnt_full = (r_cnt == CNTW'(DEPTH));

  // Packet FSM: priority pointer moves on packet start, lock spans head to tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= {1'b1, {(NPORT-1){1'b0}}};
      r_lock  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_ptr <= w_grant;
            if (!w_win_tail) begin
              r_state <= LOCKED;
              r_lock  <= w_grant;
            end
          end
        end
        LOCKED: begin
          if (w_xfer && w_win_tail) begin
            r_state <= IDLE;
            r_lock  <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_lock  <= '0;
        end
      endcase
    end
  end

  // Downstream credit tracking with a sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= CNTW'(DEPTH);
      r_err <= 1'b0;
    end else begin
      if (w_xfer && !credit_in) begin
        r_cnt <= r_cnt - CNTW'(1);
      end else if (credit_in && !w_xfer) begin
        if (w_cnt_full) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNTW'(1);
        end
      end
    end
  end

  assign grant      = w_grant;
  assign busy       = (r_state == LOCKED);
  assign credit_cnt = r_cnt;
  assign cred_err   = r_err;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed vectors with literal expectations
// plus a packet-level reference model checked every cycle.
module tb_output_port_arbiter;

  localparam int NP = 5;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic [NP-1:0] req;
  logic [NP-1:0] tail;
  logic          credit_in;
  logic [NP-1:0] grant;
  logic          busy;
  logic [CW-1:0] credit_cnt;
  logic          cred_err;

  int errors = 0;
  int checks = 0;

  output_port_arbiter #(.NPORT(NP), .DEPTH(DP), .CNTW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .cred_err   (cred_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: locked port index (-1 = none), last packet winner index,
  // credit count and error flag, all as plain integers.
  int m_lock  = -1;
  int m_last  = NP - 1;
  int m_cnt   = DP;
  bit m_err   = 1'b0;
  bit m_valid = 1'b0;

  always @(negedge clk) begin
    int win;
    logic [7:0] eg;
    win = -1;
    if (!rst && m_valid && m_cnt > 0) begin
      if (m_lock >= 0) begin
        if (req[m_lock]) win = m_lock;
      end else begin
        for (int k = 1; k <= NP; k++) begin
          int p;
          p = (m_last + k) % NP;
          if (win < 0 && req[p]) win = p;
        end
      end
    end
    eg = (win >= 0) ? (8'd1 << win) : 8'd0;
    if (rst || m_valid) chk("model_grant", {3'b0, grant}, eg);
    if (m_valid) begin
      chk("model_busy", {7'b0, busy}, {7'b0, (m_lock >= 0)});
      chk("model_cnt", {5'b0, credit_cnt}, 8'(m_cnt));
      chk("model_err", {7'b0, cred_err}, {7'b0, m_err});
    end
    if (rst) begin
      m_lock = -1; m_last = NP - 1; m_cnt = DP; m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (win >= 0) begin
        if (m_lock < 0) begin
          m_last = win;
          if (!tail[win]) m_lock = win;
        end else if (tail[win]) begin
          m_lock = -1;
        end
      end
      if (win >= 0 && !credit_in) m_cnt--;
      else if (credit_in && win < 0) begin
        if (m_cnt == DP) m_err = 1'b1;
        else m_cnt++;
      end
    end
  end

  // One cycle of directed stimulus; negative expectations are skipped.
  task automatic cyc(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                     input logic cr, input logic [4:0] eg,
                     input int ecnt, input int ebusy, input int eerr);
    rst = r; req = rq; tail = tl; credit_in = cr;
    @(negedge clk);
    chk("lit_grant", {3'b0, grant}, {3'b0, eg});
    if (ecnt  >= 0) chk("lit_cnt",  {5'b0, credit_cnt}, 8'(ecnt));
    if (ebusy >= 0) chk("lit_busy", {7'b0, busy}, 8'(ebusy));
    if (eerr  >= 0) chk("lit_err",  {7'b0, cred_err}, 8'(eerr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset then idle
    cyc(1, 5'b11111, 5'b11111, 0, 5'b00000, -1, -1, -1);
    cyc(1, 5'b11111, 5'b11111, 0, 5'b00000, -1, -1, -1);
    cyc(0, 5'b11111, 5'b11111, 1, 5'b00001, 4, 0, 0);
    cyc(1, 5'b00000, 5'b00000, 0, 5'b00000, -1, -1, -1);
    // round-robin single-flit packets
    cyc(0, 5'b10101, 5'b11111, 1, 5'b00001, 4, 0, 0);
    cyc(0, 5'b10101, 5'b11111, 1, 5'b00100, 4, 0, 0);
    cyc(0, 5'b10101, 5'b11111, 1, 5'b10000, 4, 0, 0);
    cyc(0, 5'b10101, 5'b11111, 1, 5'b00001, 4, 0, 0);
    // wormhole lock with a bubble; port 3 waits
    cyc(0, 5'b01010, 5'b00000, 0, 5'b00010, 4, 0, 0);
    cyc(0, 5'b01000, 5'b00000, 0, 5'b00000, 3, 1, 0);
    cyc(0, 5'b01010, 5'b00010, 0, 5'b00010, 3, 1, 0);
    cyc(0, 5'b01000, 5'b01000, 0, 5'b01000, 2, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 1, 5'b00000, 1, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 1, 5'b00000, 2, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 1, 5'b00000, 3, 0, 0);
    // credit stall on a 6-flit packet from port 2
    cyc(0, 5'b00100, 5'b00000, 0, 5'b00100, 4, 0, 0);
    cyc(0, 5'b00100, 5'b00000, 0, 5'b00100, 3, 1, 0);
    cyc(0, 5'b00100, 5'b00000, 0, 5'b00100, 2, 1, 0);
    cyc(0, 5'b00100, 5'b00000, 0, 5'b00100, 1, 1, 0);
    cyc(0, 5'b00100, 5'b00000, 0, 5'b00000, 0, 1, 0);
    cyc(0, 5'b00100, 5'b00000, 0, 5'b00000, 0, 1, 0);
    cyc(0, 5'b00100, 5'b00000, 1, 5'b00000, 0, 1, 0);
    cyc(0, 5'b00100, 5'b00000, 0, 5'b00100, 1, 1, 0);
    cyc(0, 5'b00100, 5'b00000, 0, 5'b00000, 0, 1, 0);
    cyc(0, 5'b00100, 5'b00000, 1, 5'b00000, 0, 1, 0);
    cyc(0, 5'b00100, 5'b00100, 0, 5'b00100, 1, 1, 0);
    cyc(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 1, 5'b00000, 1, 0, 0);
    // simultaneous transfer and credit, then overflow
    cyc(0, 5'b00001, 5'b00001, 1, 5'b00001, 2, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 1, 5'b00000, 2, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 1, 5'b00000, 3, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 1, 5'b00000, 4, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 1);
    cyc(0, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 1);
    // reset in the middle of a packet from port 4
    cyc(0, 5'b10000, 5'b00000, 0, 5'b10000, 4, 0, 1);
    cyc(1, 5'b10000, 5'b00000, 0, 5'b00000, 3, 1, 1);
    cyc(0, 5'b00011, 5'b00011, 0, 5'b00001, 4, 0, 0);
    cyc(0, 5'b00000, 5'b00000, 0, 5'b00000, 3, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port allocator that drives the 5-bit one-hot `sel` of the router's crossbar output mux.
- Arbitrates among the five input ports with round-robin priority.
- Holds a grant for the whole packet, head flit through tail flit (wormhole lock).
- Gates every grant on a downstream credit counter, so flits are only forwarded when the next-hop buffer has space.

Parameters:
- NPORT, 5, number of input ports; equals width of `grant`/`sel`.
- DEPTH, 4, downstream buffer depth in flits; reset value of the credit counter.
- CNTW, 3, credit counter width; must satisfy 2^CNTW > DEPTH.

Ports:
- clk  input  1  router clock.
- rst  input  1  synchronous active-high reset.
- req  input  NPORT  bit i = input port i holds a flit routed to this output this cycle.
- tail  input  NPORT  bit i = flit at input i is a tail flit (single-flit packet: head and tail both, tail=1).
- credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
- grant  output  NPORT  one-hot winner, or all-zero; connects to mux `sel`; a nonzero grant means a flit transfers this cycle.
- busy  output  1  1 while a multi-flit packet holds the lock.
- credit_cnt  output  CNTW  current downstream credits.
- cred_err  output  1  sticky: credit_in received with credit_cnt already at DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Registers:
  - state: IDLE/LOCKED.
  - ptr: one-hot, last packet winner.
  - lock: one-hot, locked input.
  - credit_cnt.
  - cred_err.
- Reset values:
  - state=IDLE; ptr=5'b10000, so port 0 has first priority.
  - lock=0, credit_cnt=DEPTH, cred_err=0, busy=0.
  - grant=0 in every cycle rst is high, regardless of req.
- grant is combinational in the current cycle (0-cycle latency from req). Registered state updates on the next clk edge.
- grant=0 whenever credit_cnt==0.
- IDLE, credit_cnt>0:
  - grant = first set req bit, searching from the port after ptr upward and wrapping 4->0.
  - grant=0 if req==0.
- LOCKED, credit_cnt>0:
  - grant = lock & req.
  - If the locked input has no flit this cycle (bubble), grant=0, the lock holds, and other requesters stay blocked.
- Transfer = (grant!=0). On a transfer in IDLE:
  - ptr <= grant.
  - If tail of the winner is 0: state <= LOCKED, lock <= grant, busy=1.
  - If tail of the winner is 1: stay IDLE (single-flit packet).
- Transfer in LOCKED with tail of the locked port =1: state <= IDLE, lock <= 0. The next cycle arbitrates fresh from ptr.
- ptr updates only on packet start, so priority rotates per packet, not per flit.
- Credits:
  - transfer and no credit_in: cnt-1.
  - credit_in and no transfer: cnt+1.
  - both in the same cycle: cnt unchanged.
  - neither: unchanged.
- Overflow: credit_in with cnt==DEPTH and no transfer leaves cnt=DEPTH and sets cred_err=1. cred_err stays 1 until rst.
- Underflow is impossible by construction, since no grant is issued at cnt==0.
- A credit_in arriving while cnt==0 makes grant possible the following cycle, not the same cycle.
- Reset asserted mid-packet: lock is dropped, the packet is abandoned, and all registers return to their reset values on that edge.
- busy = (state==LOCKED).
- Implementation: one-hot ptr rotation via doubled-vector priority encode. No latches. All outputs are defined for every req/tail combination.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=5'b11111 -> grant=0 during reset. After release, grant=5'b00001, credit_cnt=4, busy=0.
- Round-robin, single-flit packets: req=5'b10101 and tail=5'b11111 held for 4 cycles, credit_in pulsed every cycle -> grant sequence 00001, 00100, 10000, 00001. credit_cnt stays 4.
- Wormhole lock with bubble: port 1 sends head (tail=0). Port 3 requests continuously. Port 1 body flit is absent for 1 cycle, then a tail flit arrives -> grant 00010, 00000 (busy=1), 00010. Then 01000 on the next cycle.
- Credit stall: DEPTH=4, no credit_in, port 2 streams a 6-flit packet -> grant nonzero for 4 cycles, credit_cnt 4→0, then grant=0. One credit_in pulse -> exactly one more grant, the cycle after the pulse.
- Simultaneous transfer and credit_in at cnt=2 -> cnt stays 2. credit_in at cnt=4 with no transfer -> cnt=4, cred_err=1 and stays 1.
- Reset mid-packet: port 4 is LOCKED after its head flit; assert rst for 1 cycle -> busy=0, lock cleared, ptr=10000. Next cycle req=5'b00011 -> grant=00001.
